l2_input_sched: RTL and testbench
=================================

// Module: l2_input_sched
// PURPOSE
// - Picks which L2 input channel the L2 core services next: rsp_in, fwd_in, cpu_req or flush.
// - Sits between the input channel valid/ready pairs and the l2_rtl_top core pipeline.
// - Holds one transaction in flight, applies fixed priority with cpu_req anti-starvation,
//   and sequences a flush as a long-lived mode.
// PARAMETERS
// - STARVE_MAX  16  cycles an eligible cpu_req may lose before it is promoted above fwd_in
// - CNT_W       16  width of the promotion statistics counter
// PORTS
// - clk             in   1      clock
// - rst             in   1      reset, synchronous, active-low
// - rsp_in_valid    in   1      response pending on l2_rsp_in
// - fwd_in_valid    in   1      forward pending on l2_fwd_in
// - cpu_req_valid   in   1      request pending on l2_cpu_req
// - flush_valid     in   1      flush request pending on l2_flush
// - fwd_stall       in   1      core cannot take a fwd (address conflict); fwd ineligible
// - cpu_stall       in   1      set conflict or MSHR full; cpu_req ineligible
// - core_ready      in   1      core can start a transaction this cycle
// - txn_done        in   1      core finished the granted non-flush transaction (1-cycle pulse)
// - flush_done      in   1      core finished the flush sweep (1-cycle pulse)
// - rsp_in_ready    out  1      accept pulse to l2_rsp_in
// - fwd_in_ready    out  1      accept pulse to l2_fwd_in
// - cpu_req_ready   out  1      accept pulse to l2_cpu_req
// - flush_ready     out  1      accept pulse to l2_flush
// - grant           out  4      registered one-hot {flush,cpu,fwd,rsp} of the in-flight transaction
// - busy            out  1      FSM not in IDLE
// - promo_cnt       out  CNT_W  count of anti-starvation promotions; wraps modulo 2^CNT_W
// BEHAVIOUR
// - Reset (rst==0 at a clk edge): state=IDLE, grant=0, busy=0, promo_cnt=0, starve counter=0.
//   All *_ready outputs are 0 while rst==0.
// - Reset asserted mid-transaction aborts it; no pending done pulse is remembered.
// - *_ready outputs are combinational. A channel handshakes only when its valid and its ready
//   are both 1. At most one ready is high per cycle.
// - Eligibility: rsp=rsp_in_valid; fwd=fwd_in_valid&!fwd_stall; cpu=cpu_req_valid&!cpu_stall;
//   flush=flush_valid.
// - Priority: rsp > fwd > cpu > flush.
//   If starve==STARVE_MAX, the order is rsp > cpu > fwd > flush (promotion).
// - Flush is granted only when rsp, fwd and cpu are all ineligible.
// - IDLE: if core_ready and any channel is eligible, raise the ready of the winner.
//   Next edge: grant<=winner; state<=FLUSH if winner is flush, else BUSY.
//   If core_ready==0, no ready is raised and state stays IDLE.
// - BUSY: all readys are 0. On txn_done: grant<=0, state<=IDLE.
//   The next grant comes no earlier than the cycle after txn_done (one-cycle bubble, required).
// - FLUSH: rsp_in stays serviceable so writeback acks drain.
//   If rsp_in_valid&core_ready, rsp_in_ready=1 for that cycle. grant keeps the flush bit only.
//   fwd, cpu and flush readys are 0.
//   On flush_done: grant<=0, state<=IDLE.
//   If flush_done and an rsp handshake happen in the same cycle, both take effect.
// - txn_done in IDLE or FLUSH is ignored. flush_done in IDLE or BUSY is ignored.
// - Starve counter (width $clog2(STARVE_MAX+1)):
//   - Cleared when cpu_req handshakes, or when cpu is ineligible.
//   - Otherwise +1 on each IDLE cycle in which a different channel handshakes.
//   - Saturates at STARVE_MAX. Held in BUSY and FLUSH.
// - promo_cnt: +1 on each cpu handshake taken while starve==STARVE_MAX and fwd was eligible.
// STRUCTURE
// - cache_types.svh: l2_sched_state_t enum {IDLE, BUSY, FLUSH}.
// - cache_consts.svh: grant bit indices SCHED_RSP=0, SCHED_FWD=1, SCHED_CPU=2, SCHED_FLUSH=3.
// - One sub-module, l2_sched_starve_ctr: the saturating starve counter plus the promote flag.
// - FSM, priority logic and promo_cnt stay in the top module.
// TESTING
// - rsp, fwd and cpu valid together, core_ready=1 -> rsp_in_ready first.
//   After txn_done -> fwd, then cpu. grant sequence 0001, 0010, 0100.
// - STARVE_MAX=4; fwd always valid; cpu valid; txn_done 2 cycles after each grant ->
//   4 fwd grants, then cpu_req_ready. promo_cnt=1; starve counter back to 0.
// - cpu valid with cpu_stall=1 for 20 cycles, fwd idle -> no cpu_req_ready, starve stays 0.
//   Drop cpu_stall -> cpu_req_ready on that cycle.
// - flush_valid alone -> flush_ready, grant=1000.
//   In FLUSH, rsp_in_valid pulses 3x -> 3 rsp handshakes; cpu_req_valid never gets ready.
//   flush_done -> IDLE, then cpu granted.
// - rst=0 in BUSY with grant=0100, then a late txn_done -> grant=0, busy=0, no spurious ready.
//   The next request is granted normally.
// - txn_done with fwd_in_valid in the same cycle -> IDLE for one cycle, fwd_in_ready the cycle
//   after. Exactly one ready per cycle throughout.

Source files
------------

// File: rtl/l2_input_sched_pkg.sv
// +------------------------------------------------------------------+
// | l2_input_sched_pkg: shared types and grant indices for the L2    |
// | input scheduler.                              rev 1.0            |
// +------------------------------------------------------------------+
`default_nettype none

package l2_input_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FLUSH = 2'd2
  } l2_sched_state_t;

  localparam int SCHED_RSP   = 0;
  localparam int SCHED_FWD   = 1;
  localparam int SCHED_CPU   = 2;
  localparam int SCHED_FLUSH = 3;
  localparam int SCHED_W     = 4;

  function automatic logic [SCHED_W-1:0] sched_onehot(input int idx);
    logic [SCHED_W-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/l2_sched_starve_ctr.sv
// +------------------------------------------------------------------+
// | l2_sched_starve_ctr: saturating cpu_req starvation counter and   |
// | promotion flag.                               rev 1.0            |
// +------------------------------------------------------------------+
`default_nettype none

module l2_sched_starve_ctr
  import l2_input_sched_pkg::*;
#(
  parameter int STARVE_MAX = 16,
  parameter int STARVE_W   = $clog2(STARVE_MAX + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                idle,
  input  logic                cpu_elig,
  input  logic                cpu_hs,
  input  logic                other_hs,
  output logic [STARVE_W-1:0] starve,
  output logic                promote
);

  localparam logic [STARVE_W-1:0] STARVE_TOP = STARVE_W'(STARVE_MAX);

  // Only IDLE cycles are arbitration cycles; the count is frozen otherwise.
  always_ff @(posedge clk) begin
    if (!rst) begin
      starve <= '0;
    end else if (idle) begin
      if (cpu_hs || !cpu_elig) begin
        starve <= '0;
      end else if (other_hs && (starve != STARVE_TOP)) begin
        starve <= starve + STARVE_W'(1);
      end
    end
  end

  assign promote = (starve == STARVE_TOP);

endmodule

`default_nettype wire

// File: rtl/l2_input_sched.sv
// +------------------------------------------------------------------+
// | l2_input_sched: picks the next L2 input channel (rsp/fwd/cpu/    |
// | flush) with cpu anti-starvation and flush mode.  rev 1.0         |
// +------------------------------------------------------------------+
`default_nettype none

module l2_input_sched
  import l2_input_sched_pkg::*;
#(
  parameter int STARVE_MAX = 16,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rsp_in_valid,
  input  logic             fwd_in_valid,
  input  logic             cpu_req_valid,
  input  logic             flush_valid,
  input  logic             fwd_stall,
  input  logic             cpu_stall,
  input  logic             core_ready,
  input  logic             txn_done,
  input  logic             flush_done,
  output logic             rsp_in_ready,
  output logic             fwd_in_ready,
  output logic             cpu_req_ready,
  output logic             flush_ready,
  output logic [3:0]       grant,
  output logic             busy,
  output logic [CNT_W-1:0] promo_cnt
);

  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  l2_sched_state_t     state;
  l2_sched_state_t     state_next;
  logic                rsp_elig;
  logic                fwd_elig;
  logic                cpu_elig;
  logic                flush_elig;
  logic [SCHED_W-1:0]  winner;
  logic [SCHED_W-1:0]  ready_vec;
  logic [SCHED_W-1:0]  valid_vec;
  logic [SCHED_W-1:0]  hs_vec;
  logic                promote;
  logic [STARVE_W-1:0] starve;
  logic                other_hs;

  assign rsp_elig   = rsp_in_valid;
  assign fwd_elig   = fwd_in_valid & ~fwd_stall;
  assign cpu_elig   = cpu_req_valid & ~cpu_stall;
  assign flush_elig = flush_valid;

  // Promotion only swaps cpu above fwd; rsp always wins, flush always loses.
  always_comb begin
    winner = '0;
    if (rsp_elig) begin
      winner = sched_onehot(SCHED_RSP);
    end else if (promote && cpu_elig) begin
      winner = sched_onehot(SCHED_CPU);
    end else if (fwd_elig) begin
      winner = sched_onehot(SCHED_FWD);
    end else if (cpu_elig) begin
      winner = sched_onehot(SCHED_CPU);
    end else if (flush_elig) begin
      winner = sched_onehot(SCHED_FLUSH);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (core_ready && (winner != '0)) begin
          state_next = winner[SCHED_FLUSH] ? FLUSH : BUSY;
        end
      end
      BUSY: begin
        if (txn_done) begin
          state_next = IDLE;
        end
      end
      FLUSH: begin
        if (flush_done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready_vec = '0;
    if (rst) begin
      case (state)
        IDLE: begin
          if (core_ready) begin
            ready_vec = winner;
          end
        end
        FLUSH: begin
          // Writeback acks must keep draining while the sweep runs.
          ready_vec[SCHED_RSP] = rsp_in_valid & core_ready;
        end
        default: ready_vec = '0;
      endcase
    end
  end

  assign rsp_in_ready  = ready_vec[SCHED_RSP];
  assign fwd_in_ready  = ready_vec[SCHED_FWD];
  assign cpu_req_ready = ready_vec[SCHED_CPU];
  assign flush_ready   = ready_vec[SCHED_FLUSH];
  assign busy          = (state != IDLE);

  assign valid_vec = {flush_valid, cpu_req_valid, fwd_in_valid, rsp_in_valid};
  assign hs_vec    = ready_vec & valid_vec;
  assign other_hs  = hs_vec[SCHED_RSP] | hs_vec[SCHED_FWD] | hs_vec[SCHED_FLUSH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      grant <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (state_next != IDLE) begin
            grant <= winner;
          end
        end
        BUSY: begin
          if (txn_done) begin
            grant <= '0;
          end
        end
        FLUSH: begin
          if (flush_done) begin
            grant <= '0;
          end
        end
        default: grant <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      promo_cnt <= '0;
    end else if (hs_vec[SCHED_CPU] && promote && fwd_elig) begin
      promo_cnt <= promo_cnt + CNT_W'(1);
    end
  end

  l2_sched_starve_ctr #(
    .STARVE_MAX (STARVE_MAX),
    .STARVE_W   (STARVE_W)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .idle     (state == IDLE),
    .cpu_elig (cpu_elig),
    .cpu_hs   (hs_vec[SCHED_CPU]),
    .other_hs (other_hs),
    .starve   (starve),
    .promote  (promote)
  );

endmodule

`default_nettype wire

// File: tb/tb_l2_input_sched.sv
// +------------------------------------------------------------------+
// | tb_l2_input_sched: scenario bench for l2_input_sched with a      |
// | queue of expected ready handshakes.           rev 1.0            |
// +------------------------------------------------------------------+
`default_nettype none

module tb_l2_input_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        rsp_in_valid, fwd_in_valid, cpu_req_valid, flush_valid;
  logic        fwd_stall, cpu_stall, core_ready, txn_done, flush_done;
  logic        rsp_in_ready, fwd_in_ready, cpu_req_ready, flush_ready;
  logic [3:0]  grant;
  logic        busy;
  logic [15:0] promo_cnt;
  logic [3:0]  readys;
  logic [3:0]  exp_r;
  logic [3:0]  exp_q[$];
  int          total = 0;
  int          bad   = 0;
  bit          found;

  always #5 clk = ~clk;

  l2_input_sched #(
    .STARVE_MAX (4),
    .CNT_W      (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rsp_in_valid  (rsp_in_valid),
    .fwd_in_valid  (fwd_in_valid),
    .cpu_req_valid (cpu_req_valid),
    .flush_valid   (flush_valid),
    .fwd_stall     (fwd_stall),
    .cpu_stall     (cpu_stall),
    .core_ready    (core_ready),
    .txn_done      (txn_done),
    .flush_done    (flush_done),
    .rsp_in_ready  (rsp_in_ready),
    .fwd_in_ready  (fwd_in_ready),
    .cpu_req_ready (cpu_req_ready),
    .flush_ready   (flush_ready),
    .grant         (grant),
    .busy          (busy),
    .promo_cnt     (promo_cnt)
  );

  assign readys = {flush_ready, cpu_req_ready, fwd_in_ready, rsp_in_ready};

  // Every visible ready must match the next queued expectation.
  always @(negedge clk) begin
    total++;
    if ($countones(readys) > 1) begin
      bad++;
      $display("FAIL onehot_ready got=%b need=at most one bit", readys);
    end
    if (readys != 4'b0000) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_ready got=%b need=none", readys);
      end else begin
        exp_r = exp_q.pop_front();
        if (readys !== exp_r) begin
          bad++;
          $display("FAIL ready_order got=%b need=%b", readys, exp_r);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout need=finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_txn();
    txn_done = 1'b1;
    step();
    txn_done = 1'b0;
  endtask

  task automatic wait_hs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (readys != 4'b0000) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    core_ready = 1'b1;
    rsp_in_valid = 1'b1;
    flush_valid = 1'b1;
    repeat (3) step();
    @(negedge clk);
    total++;
    if (readys !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b need=0000", readys); end
    total++;
    if (grant !== 4'b0000) begin bad++; $display("FAIL reset_grant got=%b need=0000", grant); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b need=0", busy); end
    total++;
    if (promo_cnt !== 16'd0) begin bad++; $display("FAIL reset_promo got=%0d need=0", promo_cnt); end
    step();
    rsp_in_valid = 1'b0;
    flush_valid = 1'b0;
    rst = 1'b1;
    step();
  endtask

  task automatic test_priority();
    rsp_in_valid = 1'b1;
    fwd_in_valid = 1'b1;
    cpu_req_valid = 1'b1;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    wait_hs(found);
    total++;
    if (!found) begin bad++; $display("FAIL prio_rsp_wait got=timeout need=ready"); end
    step();
    rsp_in_valid = 1'b0;
    total++;
    if (grant !== 4'b0001 || busy !== 1'b1) begin bad++; $display("FAIL prio_grant_rsp got=%b need=0001", grant); end
    step();
    pulse_txn();
    wait_hs(found);
    total++;
    if (!found) begin bad++; $display("FAIL prio_fwd_wait got=timeout need=ready"); end
    step();
    fwd_in_valid = 1'b0;
    total++;
    if (grant !== 4'b0010) begin bad++; $display("FAIL prio_grant_fwd got=%b need=0010", grant); end
    pulse_txn();
    wait_hs(found);
    total++;
    if (!found) begin bad++; $display("FAIL prio_cpu_wait got=timeout need=ready"); end
    step();
    cpu_req_valid = 1'b0;
    total++;
    if (grant !== 4'b0100) begin bad++; $display("FAIL prio_grant_cpu got=%b need=0100", grant); end
    pulse_txn();
    step();
  endtask

  task automatic test_starvation();
    fwd_in_valid = 1'b1;
    cpu_req_valid = 1'b1;
    for (int n = 0; n < 4; n++) begin
      exp_q.push_back(4'b0010);
      wait_hs(found);
      total++;
      if (!found) begin bad++; $display("FAIL starve_fwd_wait n=%0d got=timeout need=ready", n); end
      step();
      total++;
      if (grant !== 4'b0010) begin bad++; $display("FAIL starve_fwd_grant n=%0d got=%b need=0010", n, grant); end
      step();
      pulse_txn();
    end
    exp_q.push_back(4'b0100);
    wait_hs(found);
    total++;
    if (!found) begin bad++; $display("FAIL starve_cpu_wait got=timeout need=ready"); end
    step();
    cpu_req_valid = 1'b0;
    total++;
    if (grant !== 4'b0100) begin bad++; $display("FAIL starve_cpu_grant got=%b need=0100", grant); end
    total++;
    if (promo_cnt !== 16'd1) begin bad++; $display("FAIL starve_promo got=%0d need=1", promo_cnt); end
    total++;
    if (dut.starve !== 3'd0) begin bad++; $display("FAIL starve_clear got=%0d need=0", dut.starve); end
    fwd_in_valid = 1'b0;
    step();
    pulse_txn();
    step();
  endtask

  task automatic test_cpu_stall();
    cpu_req_valid = 1'b1;
    cpu_stall = 1'b1;
    repeat (20) step();
    total++;
    if (dut.starve !== 3'd0) begin bad++; $display("FAIL stall_starve got=%0d need=0", dut.starve); end
    exp_q.push_back(4'b0100);
    cpu_stall = 1'b0;
    @(negedge clk);
    total++;
    if (cpu_req_ready !== 1'b1) begin bad++; $display("FAIL stall_release got=%b need=1", cpu_req_ready); end
    step();
    cpu_req_valid = 1'b0;
    total++;
    if (grant !== 4'b0100) begin bad++; $display("FAIL stall_grant got=%b need=0100", grant); end
    pulse_txn();
    step();
  endtask

  task automatic test_flush();
    flush_valid = 1'b1;
    exp_q.push_back(4'b1000);
    wait_hs(found);
    total++;
    if (!found) begin bad++; $display("FAIL flush_wait got=timeout need=ready"); end
    step();
    flush_valid = 1'b0;
    cpu_req_valid = 1'b1;
    total++;
    if (grant !== 4'b1000 || busy !== 1'b1) begin bad++; $display("FAIL flush_grant got=%b need=1000", grant); end
    for (int n = 0; n < 3; n++) begin
      exp_q.push_back(4'b0001);
      rsp_in_valid = 1'b1;
      @(negedge clk);
      total++;
      if (rsp_in_ready !== 1'b1) begin bad++; $display("FAIL flush_rsp n=%0d got=%b need=1", n, rsp_in_ready); end
      step();
      rsp_in_valid = 1'b0;
      step();
      total++;
      if (grant !== 4'b1000) begin bad++; $display("FAIL flush_hold n=%0d got=%b need=1000", n, grant); end
    end
    exp_q.push_back(4'b0100);
    flush_done = 1'b1;
    step();
    flush_done = 1'b0;
    total++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL flush_exit got=%b need=0000", grant); end
    wait_hs(found);
    total++;
    if (!found) begin bad++; $display("FAIL flush_cpu_wait got=timeout need=ready"); end
    step();
    cpu_req_valid = 1'b0;
    total++;
    if (grant !== 4'b0100) begin bad++; $display("FAIL flush_cpu_grant got=%b need=0100", grant); end
    pulse_txn();
    step();
  endtask

  task automatic test_reset_mid();
    cpu_req_valid = 1'b1;
    exp_q.push_back(4'b0100);
    wait_hs(found);
    total++;
    if (!found) begin bad++; $display("FAIL rmid_wait got=timeout need=ready"); end
    step();
    cpu_req_valid = 1'b0;
    total++;
    if (grant !== 4'b0100) begin bad++; $display("FAIL rmid_grant got=%b need=0100", grant); end
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    total++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL rmid_abort got=%b/%b need=0000/0", grant, busy); end
    pulse_txn();
    repeat (3) step();
    total++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL rmid_late_done got=%b/%b need=0000/0", grant, busy); end
    rsp_in_valid = 1'b1;
    exp_q.push_back(4'b0001);
    wait_hs(found);
    total++;
    if (!found) begin bad++; $display("FAIL rmid_next_wait got=timeout need=ready"); end
    step();
    rsp_in_valid = 1'b0;
    total++;
    if (grant !== 4'b0001) begin bad++; $display("FAIL rmid_next_grant got=%b need=0001", grant); end
    pulse_txn();
    step();
  endtask

  task automatic test_back_to_back();
    fwd_in_valid = 1'b1;
    exp_q.push_back(4'b0010);
    wait_hs(found);
    total++;
    if (!found) begin bad++; $display("FAIL b2b_wait got=timeout need=ready"); end
    step();
    total++;
    if (grant !== 4'b0010) begin bad++; $display("FAIL b2b_grant1 got=%b need=0010", grant); end
    step();
    exp_q.push_back(4'b0010);
    txn_done = 1'b1;
    @(negedge clk);
    total++;
    if (fwd_in_ready !== 1'b0) begin bad++; $display("FAIL b2b_bubble got=%b need=0", fwd_in_ready); end
    step();
    txn_done = 1'b0;
    @(negedge clk);
    total++;
    if (fwd_in_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL b2b_regrant got=%b/%b need=1/0", fwd_in_ready, busy); end
    step();
    fwd_in_valid = 1'b0;
    total++;
    if (grant !== 4'b0010 || busy !== 1'b1) begin bad++; $display("FAIL b2b_grant2 got=%b need=0010", grant); end
    pulse_txn();
    step();
  endtask

  initial begin
    rst = 1'b0;
    rsp_in_valid = 1'b0; fwd_in_valid = 1'b0; cpu_req_valid = 1'b0; flush_valid = 1'b0;
    fwd_stall = 1'b0; cpu_stall = 1'b0; core_ready = 1'b0;
    txn_done = 1'b0; flush_done = 1'b0;
    test_reset();
    test_priority();
    test_starvation();
    test_cpu_stall();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL leftover_expect got=%0d need=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
